// File: rtl/l1d_pkg.sv
// Shared L1D definitions: bus-unit state encodings, bus size codes and
// line-geometry helpers.
package l1d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_FETCH,
        WB_WRITE,
        LINE_RD,
        SINGLE_RD,
        SINGLE_WR,
        DONE,
        ERR
    } l1d_state_e;

    // One-hot byte counts on the core memory bus
    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

    // Width of the beat index reported to the cache
    localparam int ADDR_CNT_W = 11;

    // Byte-offset width of a line made of 64-bit beats
    function automatic int line_off_w(input int beats);
        return $clog2(beats) + 3;
    endfunction

endpackage

// File: rtl/l1d_beat_timer.sv
// Per-beat timeout counter. Counts cycles while a bus request is pending and
// flags expiry on the TIMEOUT_CYC-th waiting cycle. TIMEOUT_CYC = 0 disables it.
module l1d_beat_timer
    import l1d_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CNT_W-1:0] cnt;

    // Count waiting cycles; restart whenever a beat ends or no request is out
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!run || clr)
            cnt <= '0;
        else if (cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT_CYC != 0) && run && (cnt == LAST);

endmodule

// File: rtl/l1d_bus_ctrl.sv
// L1D cache bus unit: converts level-held cache requests into single-
// outstanding 64-bit req/ack/err bus transactions (single read/write,
// line refill, dirty-line write-back).
module l1d_bus_ctrl
    import l1d_pkg::*;
#(
    parameter int LINE_BEATS  = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_through_req,
    input  logic                  read_req,
    input  logic                  read_line_req,
    input  logic                  write_line_req,
    input  logic [3:0]            L1_size,
    input  logic [63:0]           pa,
    input  logic [63:0]           wt_data,
    output logic [63:0]           line_data,
    output logic [ADDR_CNT_W-1:0] addr_count,
    output logic                  line_write,
    output logic                  cache_entry_refill,
    output logic                  trans_rdy,
    output logic                  bus_error,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [63:0]           bus_addr,
    output logic [3:0]            bus_size,
    output logic [63:0]           bus_wdata,
    input  logic [63:0]           bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err
);

    localparam int OFF_W  = line_off_w(LINE_BEATS);
    localparam int BEAT_W = OFF_W - 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    l1d_state_e        state;
    logic [63:OFF_W]   line_hi;    // line base, offset bits implied zero
    logic [BEAT_W-1:0] beat;       // beat currently on the bus
    logic [BEAT_W-1:0] next_beat;
    logic              expired;
    logic              abort;

    function automatic logic [63:0] beat_addr(input logic [63:OFF_W] hi,
                                              input logic [BEAT_W-1:0] b);
        return {hi, b, 3'b000};
    endfunction

    assign next_beat = beat + 1'b1;
    // bus_err beats bus_ack; an ack in the expiring cycle still completes the beat
    assign abort     = bus_err || (expired && !bus_ack);

    l1d_beat_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (bus_req),
        .clr     (bus_ack | bus_err),
        .expired (expired)
    );

    // Transaction FSM with registered bus and cache-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            line_hi            <= '0;
            beat               <= '0;
            line_data          <= '0;
            addr_count         <= '0;
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_size           <= '0;
            bus_wdata          <= '0;
        end else begin
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;

            if (bus_req && abort) begin
                // Remaining beats are dropped; the cache sees only bus_error
                bus_req   <= 1'b0;
                bus_error <= 1'b1;
                state     <= ERR;
            end else begin
                case (state)
                    IDLE: begin
                        addr_count <= '0;
                        beat       <= '0;
                        if (write_line_req) begin
                            line_hi <= pa[63:OFF_W];
                            state   <= WB_FETCH;
                        end else if (read_line_req) begin
                            line_hi  <= pa[63:OFF_W];
                            bus_req  <= 1'b1;
                            bus_we   <= 1'b0;
                            bus_addr <= {pa[63:OFF_W], {OFF_W{1'b0}}};
                            bus_size <= SZ_D;
                            state    <= LINE_RD;
                        end else if (read_req) begin
                            bus_req  <= 1'b1;
                            bus_we   <= 1'b0;
                            bus_addr <= pa;
                            bus_size <= L1_size;
                            state    <= SINGLE_RD;
                        end else if (write_through_req) begin
                            bus_req   <= 1'b1;
                            bus_we    <= 1'b1;
                            bus_addr  <= pa;
                            bus_size  <= L1_size;
                            bus_wdata <= wt_data;
                            state     <= SINGLE_WR;
                        end
                    end
                    WB_FETCH: begin
                        // SRAM output for addr_count is valid by the end of this cycle
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= beat_addr(line_hi, beat);
                        bus_size  <= SZ_D;
                        bus_wdata <= wt_data;
                        state     <= WB_WRITE;
                    end
                    WB_WRITE: begin
                        if (bus_ack) begin
                            bus_req <= 1'b0;
                            if (beat == LAST_BEAT) begin
                                trans_rdy <= 1'b1;
                                state     <= DONE;
                            end else begin
                                beat       <= next_beat;
                                addr_count <= ADDR_CNT_W'(next_beat);
                                state      <= WB_FETCH;
                            end
                        end
                    end
                    LINE_RD: begin
                        if (bus_ack) begin
                            // addr_count trails the bus so it names the beat being written
                            line_data  <= bus_rdata;
                            line_write <= 1'b1;
                            addr_count <= ADDR_CNT_W'(beat);
                            if (beat == LAST_BEAT) begin
                                bus_req            <= 1'b0;
                                trans_rdy          <= 1'b1;
                                cache_entry_refill <= 1'b1;
                                state              <= DONE;
                            end else begin
                                beat     <= next_beat;
                                bus_addr <= beat_addr(line_hi, next_beat);
                            end
                        end
                    end
                    SINGLE_RD: begin
                        if (bus_ack) begin
                            line_data <= bus_rdata;
                            bus_req   <= 1'b0;
                            trans_rdy <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    SINGLE_WR: begin
                        if (bus_ack) begin
                            bus_req   <= 1'b0;
                            trans_rdy <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    ERR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_l1d_bus_ctrl.sv
// Scoreboard bench for l1d_bus_ctrl: stimulus pushes expected bus beats,
// refill writes and completions; one negedge process models the bus slave
// and cache SRAM side and pops/compares whenever the DUT presents an output.
module tb_l1d_bus_ctrl;
    import l1d_pkg::*;

    localparam int LB = 16;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [3:0]  size;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        logic [10:0] idx;
        logic [63:0] data;
    } lw_t;

    typedef struct {
        logic        tr;
        logic        cer;
        logic        chk_data;
        logic [63:0] data;
        int          wait_n;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_through_req, read_req, read_line_req, write_line_req;
    logic [3:0]  L1_size;
    logic [63:0] pa, wt_data, wt_fixed;
    logic [63:0] line_data;
    logic [10:0] addr_count;
    logic        line_write, cache_entry_refill, trans_rdy, bus_error;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_size;
    logic        bus_ack, bus_err;

    // Bench-side configuration, written only by the stimulus process
    logic        sram_mode;
    int          resp_delay, err_beat, txn_id;
    logic        no_ack, fin;
    logic [63:0] rdata_base;

    beat_t q_beat[$];
    lw_t   q_lw[$];
    done_t q_done[$];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Cache SRAM: its output follows the address held in addr_count
    assign wt_data = sram_mode ? (64'hA0 + {53'd0, addr_count}) : wt_fixed;

    l1d_bus_ctrl #(.LINE_BEATS(LB), .TIMEOUT_CYC(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .write_through_req  (write_through_req),
        .read_req           (read_req),
        .read_line_req      (read_line_req),
        .write_line_req     (write_line_req),
        .L1_size            (L1_size),
        .pa                 (pa),
        .wt_data            (wt_data),
        .line_data          (line_data),
        .addr_count         (addr_count),
        .line_write         (line_write),
        .cache_entry_refill (cache_entry_refill),
        .trans_rdy          (trans_rdy),
        .bus_error          (bus_error),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_size           (bus_size),
        .bus_wdata          (bus_wdata),
        .bus_rdata          (bus_rdata),
        .bus_ack            (bus_ack),
        .bus_err            (bus_err)
    );

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    // Bus slave + monitor
    initial begin : mon
        int cyc = 0;
        int run = 0;
        int wait_cnt = 0;
        int beat_n = 0;
        int last_txn = 0;
        beat_t b;
        lw_t   l;
        done_t d;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                chk("watchdog", 128'(cyc), 128'(0));
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
            if (rst) begin
                chk("reset_ctl", {bus_req, bus_we, bus_size, line_write, trans_rdy, bus_error,
                                  cache_entry_refill, addr_count}, '0);
                chk("reset_data", bus_addr | bus_wdata | line_data, '0);
                run = 0; wait_cnt = 0; bus_ack = 1'b0; bus_err = 1'b0;
            end else begin
                if (trans_rdy || bus_error || cache_entry_refill) begin
                    if (q_done.size() == 0)
                        chk("unexpected_done", {trans_rdy, bus_error, cache_entry_refill}, '0);
                    else begin
                        d = q_done.pop_front();
                        chk("done_kind", {trans_rdy, bus_error, cache_entry_refill}, {d.tr, !d.tr, d.cer});
                        chk("done_req_low", bus_req, 1'b0);
                        if (d.chk_data) chk("done_line_data", line_data, d.data);
                        if (d.wait_n >= 0) chk("timeout_wait", 128'(run), 128'(d.wait_n));
                    end
                end
                if (line_write) begin
                    if (q_lw.size() == 0)
                        chk("unexpected_line_write", {line_write, addr_count}, '0);
                    else begin
                        l = q_lw.pop_front();
                        chk("lw_addr_count", addr_count, l.idx);
                        chk("lw_line_data", line_data, l.data);
                    end
                end
                bus_ack = 1'b0; bus_err = 1'b0;
                if (txn_id != last_txn) begin
                    last_txn = txn_id;
                    beat_n   = 0;
                end
                if (bus_req) begin
                    if (!no_ack && wait_cnt >= resp_delay) begin
                        if (q_beat.size() == 0)
                            chk("unexpected_beat", {bus_req, bus_addr}, '0);
                        else begin
                            b = q_beat.pop_front();
                            chk("beat_addr", bus_addr, b.addr);
                            chk("beat_we_size", {bus_we, bus_size}, {b.we, b.size});
                            if (b.we) chk("beat_wdata", bus_wdata, b.wdata);
                        end
                        if (beat_n == err_beat) bus_err = 1'b1;
                        else begin
                            bus_ack   = 1'b1;
                            bus_rdata = rdata_base + 64'(beat_n);
                        end
                        beat_n++;
                        wait_cnt = 0;
                        run = 0;
                    end else begin
                        wait_cnt++;
                        run++;
                    end
                end else begin
                    wait_cnt = 0;
                    run = 0;
                end
            end
            if (fin) begin
                chk("beats_left", 128'(q_beat.size()), 128'(0));
                chk("line_writes_left", 128'(q_lw.size()), 128'(0));
                chk("dones_left", 128'(q_done.size()), 128'(0));
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
        end
    end

    task automatic push_beat(input logic [63:0] a, input logic we, input logic [3:0] sz, input logic [63:0] wd);
        beat_t b;
        b.addr = a; b.we = we; b.size = sz; b.wdata = wd;
        q_beat.push_back(b);
    endtask

    task automatic push_lw(input int k, input logic [63:0] data);
        lw_t l;
        l.idx = 11'(k); l.data = data;
        q_lw.push_back(l);
    endtask

    task automatic push_done(input logic tr, input logic cer, input logic cd, input logic [63:0] data, input int wn);
        done_t d;
        d.tr = tr; d.cer = cer; d.chk_data = cd; d.data = data; d.wait_n = wn;
        q_done.push_back(d);
    endtask

    // kind: 0 write-through, 1 read, 2 refill, 3 write-back, 4 write-back + refill
    task automatic start(input int kind, input logic [63:0] a, input logic [3:0] sz);
        @(negedge clk); #1;
        txn_id++;
        pa = a; L1_size = sz;
        write_through_req = (kind == 0);
        read_req          = (kind == 1);
        read_line_req     = (kind == 2) || (kind == 4);
        write_line_req    = (kind == 3) || (kind == 4);
    endtask

    task automatic finish_txn();
        int n = 0;
        while (!(trans_rdy || bus_error) && n < 400) begin
            @(negedge clk);
            n++;
        end
        #1;
        write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0; write_line_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0; write_line_req = 1'b0;
        L1_size = '0; pa = '0; wt_fixed = '0; sram_mode = 1'b0;
        resp_delay = 0; err_beat = -1; txn_id = 0; no_ack = 1'b0; fin = 1'b0; rdata_base = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Single read, ack after 3 waiting cycles
        resp_delay = 3; rdata_base = 64'hDEAD_BEEF;
        push_beat(64'h1000_0004, 1'b0, SZ_W, '0);
        push_done(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, -1);
        start(1, 64'h1000_0004, SZ_W);
        finish_txn();

        // Line refill from the middle of a line
        resp_delay = 0; rdata_base = 64'h5500;
        for (int k = 0; k < LB; k++) begin
            push_beat(64'h2000_0000 + 64'(8 * k), 1'b0, SZ_D, '0);
            push_lw(k, 64'h5500 + 64'(k));
        end
        push_done(1'b1, 1'b1, 1'b0, '0, -1);
        start(2, 64'h2000_0048, SZ_W);
        finish_txn();

        // Dirty-line write-back, data from the SRAM model
        resp_delay = 1; sram_mode = 1'b1;
        for (int k = 0; k < LB; k++)
            push_beat(64'h3000_0100 + 64'(8 * k), 1'b1, SZ_D, 64'hA0 + 64'(k));
        push_done(1'b1, 1'b0, 1'b0, '0, -1);
        start(3, 64'h3000_0128, SZ_D);
        finish_txn();

        // Single write-through
        resp_delay = 2; sram_mode = 1'b0; wt_fixed = 64'h0123_4567_89AB_CDEF;
        push_beat(64'h8000_0003, 1'b1, SZ_B, 64'h0123_4567_89AB_CDEF);
        push_done(1'b1, 1'b0, 1'b0, '0, -1);
        start(0, 64'h8000_0003, SZ_B);
        finish_txn();

        // Refill aborted by bus_err on beat 5
        resp_delay = 1; rdata_base = 64'h100; err_beat = 5;
        for (int k = 0; k < 6; k++) push_beat(64'h4000_0000 + 64'(8 * k), 1'b0, SZ_D, '0);
        for (int k = 0; k < 5; k++) push_lw(k, 64'h100 + 64'(k));
        push_done(1'b0, 1'b0, 1'b0, '0, -1);
        start(2, 64'h4000_0000, SZ_D);
        finish_txn();
        err_beat = -1;

        // Write-through with a silent bus: timeout after 4 waiting cycles
        no_ack = 1'b1; wt_fixed = 64'h1122_3344_5566_7788;
        push_done(1'b0, 1'b0, 1'b0, '0, 4);
        start(0, 64'h5000_0010, SZ_B);
        finish_txn();
        no_ack = 1'b0;

        // Write-back wins over a simultaneous refill request
        resp_delay = 0; sram_mode = 1'b1;
        for (int k = 0; k < LB; k++)
            push_beat(64'h6000_0000 + 64'(8 * k), 1'b1, SZ_D, 64'hA0 + 64'(k));
        push_done(1'b1, 1'b0, 1'b0, '0, -1);
        start(4, 64'h6000_0000, SZ_D);
        finish_txn();
        sram_mode = 1'b0;

        // Async reset in the middle of a refill
        resp_delay = 0; rdata_base = 64'h700;
        for (int k = 0; k < 4; k++) push_beat(64'h7000_0000 + 64'(8 * k), 1'b0, SZ_D, '0);
        for (int k = 0; k < 3; k++) push_lw(k, 64'h700 + 64'(k));
        start(2, 64'h7000_0000, SZ_D);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        read_line_req = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Next refill restarts from beat 0
        rdata_base = 64'h900;
        for (int k = 0; k < LB; k++) begin
            push_beat(64'h7000_0000 + 64'(8 * k), 1'b0, SZ_D, '0);
            push_lw(k, 64'h900 + 64'(k));
        end
        push_done(1'b1, 1'b1, 1'b0, '0, -1);
        start(2, 64'h7000_0040, SZ_D);
        finish_txn();

        repeat (3) @(negedge clk);
        #1 fin = 1'b1;
    end

endmodule

// File: doc/l1d_bus_ctrl.md
# l1d_bus_ctrl

Cache bus unit sitting directly downstream of the L1 data cache. It turns the cache's level-held requests into 64-bit transactions on the core memory bus:
- write-through (write_through_req)
- single read (read_req)
- line refill (read_line_req)
- dirty-line write-back (write_line_req)

It returns per-beat refill data, the beat counter, completion/error pulses and the refill-commit strobe to the cache. Bus side is a simple req/ack/err single-outstanding interface.

## Interface
Parameters:
- LINE_BEATS, 16: 64-bit beats per cache line; power of two, 2..1024
- TIMEOUT_CYC, 255: cycles without bus_ack/bus_err before a beat is declared failed; 0 disables the timeout

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- write_through_req  in  1  level; write wt_data to pa, L1_size bytes
- read_req  in  1  level; single read of pa, L1_size bytes
- read_line_req  in  1  level; refill the line containing pa
- write_line_req  in  1  level; write back the line containing pa, data from wt_data
- L1_size  in  4  one-hot byte count (0001/0010/0100/1000)
- pa  in  64  physical address
- wt_data  in  64  write data; during write-back, cache SRAM output for addr_count (1-cycle read latency)
- line_data  out  64  registered read data to cache
- addr_count  out  11  current beat index, zero-extended
- line_write  out  1  pulse: line_data valid for beat addr_count of a refill
- cache_entry_refill  out  1  pulse: refill completed successfully
- trans_rdy  out  1  pulse: transaction completed successfully
- bus_error  out  1  pulse: transaction aborted
- bus_req  out  1  bus request, held until ack/err
- bus_we  out  1  1 = write
- bus_addr  out  64  beat address
- bus_size  out  4  byte count; 1000 for line beats
- bus_wdata  out  64  write data
- bus_rdata  in  64  read data, valid with bus_ack
- bus_ack  in  1  beat complete
- bus_err  in  1  beat failed; wins over bus_ack in the same cycle

## Operation
States: IDLE, WB_FETCH, WB_WRITE, LINE_RD, SINGLE_RD, SINGLE_WR, DONE, ERR.

**IDLE.** Samples requests. Priority is write_line_req > read_line_req > read_req > write_through_req. Latches pa and L1_size on entry to a transaction. The line base is pa with the low log2(LINE_BEATS*8) bits cleared. addr_count is cleared to 0.

**WB_FETCH.** One cycle while the cache SRAM reads beat addr_count. Then goes to WB_WRITE, latching wt_data into bus_wdata.

**WB_WRITE.** bus_req=1, bus_we=1, bus_addr = base + 8*addr_count.
- On ack, last beat → DONE.
- On ack, otherwise → addr_count+1, WB_FETCH.

**LINE_RD.** bus_req=1, bus_we=0, bus_addr = base + 8*addr_count.
- On ack: line_data ← bus_rdata, line_write pulses next cycle with the addr_count value of that beat.
- Last beat → DONE, with cache_entry_refill pulsing alongside trans_rdy.

**SINGLE_RD / SINGLE_WR.** One beat at the latched pa with the latched L1_size. Read data goes to line_data. Write data is wt_data latched at entry. On ack → DONE.

**DONE.** trans_rdy=1 for one cycle, then IDLE. The cache changes state on that same edge, so a request still high in IDLE is a new transaction (e.g. the next dirty line during a full sync).

**ERR.** Entered on bus_err, or on timeout (counter reaches TIMEOUT_CYC within a beat). bus_error=1 for one cycle, then IDLE. Remaining beats are abandoned; cache_entry_refill is never asserted.

**Boundary conditions.**
- Requests are not re-sampled mid-transaction; a deassert mid-transfer is ignored.
- The timeout counter clears at each new beat.

## Timing
- Reset: all outputs 0, state IDLE, addr_count 0. Async reset mid-transfer drops bus_req immediately; the bus must tolerate an abandoned beat.
- Request to first bus_req: 1 cycle for read/write/refill, 2 cycles for write-back (IDLE, WB_FETCH).
- bus_req, bus_addr, bus_we, bus_wdata are registered and stable until ack/err.
- Refill: line_write is 1 cycle after each bus_ack. Write-back beat cost: 1 + (ack wait) cycles.
- trans_rdy / bus_error are single-cycle pulses, never both, never two back-to-back without an IDLE between.

## Structure
- Shared package (the one already holding the l1d state encodings) gets the state enum, the bus size encodings (SZ_B=0001 … SZ_D=1000), and the LINE_BEATS-derived offset width.
- Natural sub-module: l1d_beat_timer (per-beat timeout counter with clear/expire).

## Test plan
- Single read: read_req, pa=0x1000_0004, size 0100, ack after 3 cycles with rdata 0xDEAD_BEEF → bus_addr=0x1000_0004, bus_size=0100, line_data=0xDEAD_BEEF with trans_rdy pulse, no line_write.
- Refill, LINE_BEATS=16, pa=0x2000_0048: bus_addr 0x2000_0000..0x2000_0078 step 8; 16 line_write pulses with addr_count 0..15; cache_entry_refill and trans_rdy together once.
- Write-back: model 1-cycle SRAM returning 0xA0+k for beat k → bus_wdata sequence 0xA0..0xAF at consecutive addresses; one trans_rdy.
- Error on beat 5 of a refill: bus_err → exactly 5 line_write pulses, bus_error pulse, no trans_rdy, no cache_entry_refill, back in IDLE.
- Timeout, TIMEOUT_CYC=4: write_through_req with no ack → bus_error after 4 waiting cycles, bus_req deasserted.
- Priority / reset: write_line_req and read_line_req together → write-back first. Async rst mid-refill → all outputs 0 immediately; the next request restarts at addr_count 0.
